line_arbiter: RTL
=================

# line_arbiter

Two-port line-request arbiter that sits between the split L1 caches (instruction side, data side) and the unified L2. It is the initiator on the L2 request interface: it grants one upstream L1 miss at a time and registers that request onto the 256-bit L2 interface. It holds the request until the L2 returns `mem_resp`, then routes the response back to the granted L1. The `mem_*` ports use the same handshake the L2 implements.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, byte address width.
- `LINE_WIDTH`, 256, cache line width in bits.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `i_address`  in  ADDR_WIDTH  I-cache miss address.
- `i_read`  in  1  I-cache line read request; I side never writes.
- `i_resp`  out  1  I-side completion, one-cycle pulse.
- `i_rdata`  out  LINE_WIDTH  line returned to I-cache.
- `d_address`  in  ADDR_WIDTH  D-cache miss or writeback address.
- `d_wdata`  in  LINE_WIDTH  D-cache writeback line.
- `d_read`  in  1  D-cache line read request.
- `d_write`  in  1  D-cache line write request.
- `d_resp`  out  1  D-side completion, one-cycle pulse.
- `d_rdata`  out  LINE_WIDTH  line returned to D-cache.
- `mem_address`  out  ADDR_WIDTH  line-aligned address to L2.
- `mem_wdata`  out  LINE_WIDTH  write line to L2.
- `mem_read`  out  1  L2 read strobe.
- `mem_write`  out  1  L2 write strobe.
- `mem_resp`  in  1  L2 completion.
- `mem_rdata`  in  LINE_WIDTH  L2 read line.

## Operation
- FSM states: `IDLE`, `GRANT_I`, `GRANT_D`.
- **IDLE**
  - A D request is pending when `d_read|d_write` is high. An I request is pending when `i_read` is high.
  - If exactly one side is pending, grant it.
  - If both are pending, the winner is chosen by the policy in Configuration.
  - On grant, register the following at the same edge:
    - `mem_address <= {addr[ADDR_WIDTH-1:5], 5'b0}`.
    - `mem_wdata <= d_wdata` (D grant only; unchanged otherwise).
    - `mem_read` and `mem_write` from the granted side's command.
  - If `d_read` and `d_write` are both high, the write wins: `mem_write=1`, `mem_read=0`.
- **GRANT_x**
  - `mem_address`, `mem_wdata`, `mem_read` and `mem_write` hold stable regardless of upstream changes.
  - On the `mem_resp` cycle:
    - Drive `x_resp=1` and `x_rdata=mem_rdata` combinationally in that cycle.
    - At the edge, clear `mem_read` and `mem_write` and return to IDLE.
- The non-granted side's resp stays 0. `i_rdata` and `d_rdata` always equal `mem_rdata`, but are meaningful only when the corresponding resp is high.
- `mem_resp` in IDLE is ignored; no upstream resp is generated.
- Upstream request drop before resp: the L2 transaction still completes, and the resp pulse is still issued to the granted side.

## Timing
- Reset (asynchronous, `rst_n=0`):
  - State goes to IDLE.
  - `mem_read=0`, `mem_write=0`, `mem_address=0`, `mem_wdata=0`.
  - `i_resp=0`, `d_resp=0`.
  - Round-robin pointer resets to "last = I".
- Reset mid-transaction aborts immediately. There is no resp after reset release.
- Latency: a request sampled in IDLE at edge k gives `mem_read`/`mem_write` high from cycle k+1.
- With `mem_resp` in cycle n, upstream resp is in cycle n, and the FSM is in IDLE in cycle n+1.
- Earliest next grant is edge n+1, with the L2 strobe visible in n+2. This gives one mandatory turnaround cycle, so a stale request held in cycle n is never re-granted.
- `mem_read` and `mem_write` are never high in the same cycle.
- At most one of `i_resp` and `d_resp` is high per cycle.

## Configuration
- Macro: `LINE_ARBITER_RR_EN`.
- Defined: round-robin on a tie.
  - The side not granted last wins.
  - The pointer updates on every grant.
  - After reset, D wins the first tie.
- Undefined: fixed priority, D always wins a tie. There is no pointer register, and I can be starved by back-to-back D requests.

## Test plan
- Single I read: `i_read=1`, `i_address=0x0000_1234` → `mem_read=1` and `mem_address=0x0000_1220` next cycle; `mem_resp` with `mem_rdata=0xA5..A5` → `i_resp=1`, `i_rdata=0xA5..A5`, `d_resp=0`.
- D writeback: `d_write=1`, `d_address=0x8000_0040`, `d_wdata=0xDEAD..BEEF` → `mem_write=1`, `mem_address=0x8000_0040`, `mem_wdata` matches; `mem_wdata` is held while `d_wdata` toggles; `d_resp` is pulsed on `mem_resp`.
- Tie: `i_read` and `d_read` high in the same cycle, held through two responses:
  - With RR: D is served first, then I after the turnaround cycle.
  - Without RR: D is served twice while D stays requesting.
- Turnaround: `mem_resp` in cycle 10 with requests still high → `mem_read=0` in cycle 11, new strobe in cycle 12.
- Reset mid-transaction: `rst_n` low during `GRANT_D` → strobes and resps are 0 asynchronously, and there is no `d_resp` after release.
- Illegal D command: `d_read=d_write=1` → only `mem_write=1`; spurious `mem_resp` in IDLE → no resp pulse.

Source files
------------

// File: rtl/line_arbiter_if.sv
// Bundle of the I-side, D-side and L2 line-request signals around line_arbiter.
// master: the arbiter's view; slave: the L1 caches plus L2 seen from outside.
interface line_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LINE_WIDTH = 256
);
    logic [ADDR_WIDTH-1:0] i_address;
    logic                  i_read;
    logic                  i_resp;
    logic [LINE_WIDTH-1:0] i_rdata;

    logic [ADDR_WIDTH-1:0] d_address;
    logic [LINE_WIDTH-1:0] d_wdata;
    logic                  d_read;
    logic                  d_write;
    logic                  d_resp;
    logic [LINE_WIDTH-1:0] d_rdata;

    logic [ADDR_WIDTH-1:0] mem_address;
    logic [LINE_WIDTH-1:0] mem_wdata;
    logic                  mem_read;
    logic                  mem_write;
    logic                  mem_resp;
    logic [LINE_WIDTH-1:0] mem_rdata;

    modport master (
        input  i_address, i_read, d_address, d_wdata, d_read, d_write, mem_resp, mem_rdata,
        output i_resp, i_rdata, d_resp, d_rdata, mem_address, mem_wdata, mem_read, mem_write
    );

    modport slave (
        output i_address, i_read, d_address, d_wdata, d_read, d_write, mem_resp, mem_rdata,
        input  i_resp, i_rdata, d_resp, d_rdata, mem_address, mem_wdata, mem_read, mem_write
    );
endinterface

// File: rtl/line_arbiter.sv
// Two-port (I/D) line-request arbiter in front of the unified L2, one transaction at a time.
// Define LINE_ARBITER_RR_EN for round-robin tie-break; default is fixed D priority.
module line_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LINE_WIDTH = 256
) (
    input logic           clk,
    input logic           rst_n,
    line_arbiter_if.master bus
);
    typedef enum logic [1:0] {StIdle, StGrantI, StGrantD} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
    logic                  read_q, read_d;
    logic                  write_q, write_d;

    logic d_pend, i_pend, d_wins_tie, win_d, win_i;

    assign d_pend = bus.d_read | bus.d_write;
    assign i_pend = bus.i_read;

`ifdef LINE_ARBITER_RR_EN
    logic last_was_d_q;

    assign d_wins_tie = ~last_was_d_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_was_d_q <= 1'b0;
        end else if (state_q == StIdle && (d_pend || i_pend)) begin
            last_was_d_q <= win_d;
        end
    end
`else
    assign d_wins_tie = 1'b1;
`endif

    assign win_d = d_pend & (~i_pend | d_wins_tie);
    assign win_i = i_pend & ~win_d;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        read_d  = read_q;
        write_d = write_q;
        case (state_q)
            StIdle: begin
                if (win_d) begin
                    state_d = StGrantD;
                    addr_d  = {bus.d_address[ADDR_WIDTH-1:5], 5'b0};
                    wdata_d = bus.d_wdata;
                    // Write dominates an illegal read+write command.
                    write_d = bus.d_write;
                    read_d  = ~bus.d_write;
                end else if (win_i) begin
                    state_d = StGrantI;
                    addr_d  = {bus.i_address[ADDR_WIDTH-1:5], 5'b0};
                    read_d  = 1'b1;
                    write_d = 1'b0;
                end
            end
            StGrantI, StGrantD: begin
                if (bus.mem_resp) begin
                    state_d = StIdle;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            wdata_q <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            read_q  <= read_d;
            write_q <= write_d;
        end
    end

    assign bus.mem_address = addr_q;
    assign bus.mem_wdata   = wdata_q;
    assign bus.mem_read    = read_q;
    assign bus.mem_write   = write_q;

    assign bus.i_resp  = (state_q == StGrantI) & bus.mem_resp;
    assign bus.d_resp  = (state_q == StGrantD) & bus.mem_resp;
    assign bus.i_rdata = bus.mem_rdata;
    assign bus.d_rdata = bus.mem_rdata;
endmodule
